// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// with the carry rippling between cycles through a single register.
`timescale 1ns/1ps

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | one DIGIT slice added per clock, STEPS clocks total
  // DONE   | one-cycle result pulse; start here chains the next operation
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_nxt;
  logic             last;

  assign dsum    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + (DIGIT+1)'(carry);
  // New digit enters at the top so the result is LSB-aligned after STEPS shifts.
  assign res_nxt = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign last    = (cnt == CW'(STEPS - 1));

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          res   <= res_nxt;
          carry <= dsum[DIGIT];
          if (last) begin
            state     <= S_DONE;
            sum       <= res_nxt;
            carry_out <= dsum[DIGIT];
            overflow  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (start) begin
            // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
            state <= S_RUN;
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            res   <= '0;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: DIGIT=1 and DIGIT=4 instances, directed
// corner cases then a randomized sweep against an arithmetic reference model.
`timescale 1ns/1ps

module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st [2];
  logic       sb [2];
  logic [7:0] aa [2];
  logic [7:0] bb [2];
  logic       bz [2];
  logic       dn [2];
  logic [7:0] sm [2];
  logic       co [2];
  logic       ov [2];

  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [9:0] lastv [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .a(aa[0]), .b(bb[0]),
    .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .carry_out(co[0]), .overflow(ov[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .a(aa[1]), .b(bb[1]),
    .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .carry_out(co[1]), .overflow(ov[1]));

  function automatic int steps(int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(logic s, logic [7:0] x, logic [7:0] y);
    exp_t e;
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r;
    int sr;
    if (!s) begin
      r  = ux + uy;
      sr = sx + sy;
      e.c = (r > 255);
    end else begin
      r  = ux - uy;
      sr = sx - sy;
      e.c = (ux >= uy);
    end
    e.s  = 8'(r & 255);
    e.o  = (sr > 127) || (sr < -128);
    e.t0 = 0;
    return e;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s dut%0d: got %0h required %0h (cycle %0d)", nm, d, act, req, cyc);
  endtask

  task automatic note_fail(string nm, int d);
    total++;
    $display("FAIL %s dut%0d: bound expired (cycle %0d)", nm, d, cyc);
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(int d);
    exp_t e;
    if (rst_n === 1'b1) begin
      if (dn[d] === 1'b1) begin
        chk("busy_with_done", d, 32'(bz[d]), 0);
        if (qsize(d) == 0) begin
          chk("spurious_done", d, 32'(dn[d]), 0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("sum", d, 32'(sm[d]), 32'(e.s));
          chk("carry_out", d, 32'(co[d]), 32'(e.c));
          chk("overflow", d, 32'(ov[d]), 32'(e.o));
          chk("latency", d, 32'(cyc - e.t0), 32'(steps(d)));
          lastv[d] = {e.s, e.c, e.o};
        end
      end else if (bz[d] === 1'b1) begin
        chk("hold_during_run", d, 32'({sm[d], co[d], ov[d]}), 32'(lastv[d]));
      end
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic issue(int d, logic s, logic [7:0] x, logic [7:0] y, bit keep);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (bz[d] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) note_fail("issue_wait", d);
    st[d] = 1'b1;
    sb[d] = s;
    aa[d] = x;
    bb[d] = y;
    @(posedge clk);
    #1;
    e = model(s, x, y);
    e.t0 = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    chk("busy_after_start", d, 32'(bz[d]), 1);
    if (!keep) st[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n = 0;
    while ((qsize(d) != 0 || bz[d] !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) note_fail("drain", d);
  endtask

  task automatic sweep(int d, int cnt);
    for (int i = 0; i < cnt; i++) begin
      issue(d, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b1; sb[d] = 1'b0; aa[d] = 8'h5A; bb[d] = 8'h33;
      lastv[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 32'(bz[d]), 0);
      chk("rst_done", d, 32'(dn[d]), 0);
      chk("rst_outs", d, 32'({sm[d], co[d], ov[d]}), 0);
    end
    @(negedge clk);
    st[0] = 1'b0; st[1] = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_rst", 0, 32'(bz[0]), 0);
    chk("idle_after_rst", 1, 32'(bz[1]), 0);

    issue(0, 1'b0, 8'hFF, 8'h01, 1'b0);
    issue(0, 1'b0, 8'h7F, 8'h01, 1'b0);
    issue(0, 1'b1, 8'h05, 8'h07, 1'b0);
    issue(0, 1'b1, 8'h80, 8'h01, 1'b0);
    drain(0);

    // A mid-RUN start pulse with different operands must not disturb the result.
    issue(0, 1'b0, 8'h3C, 8'h21, 1'b0);
    repeat (2) @(negedge clk);
    st[0] = 1'b1; sb[0] = 1'b1; aa[0] = 8'hFF; bb[0] = 8'h0F;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    drain(0);

    // start held continuously: second operands accepted on the DONE edge.
    issue(0, 1'b0, 8'h10, 8'h20, 1'b1);
    issue(0, 1'b1, 8'h20, 8'h10, 1'b0);
    drain(0);

    // Reset in the middle of RUN discards the operation.
    issue(0, 1'b0, 8'h44, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    lastv[0] = '0;
    lastv[1] = '0;
    chk("midrst_busy", 0, 32'(bz[0]), 0);
    chk("midrst_done", 0, 32'(dn[0]), 0);
    chk("midrst_outs", 0, 32'({sm[0], co[0], ov[0]}), 0);
    chk("midrst_outs", 1, 32'({sm[1], co[1], ov[1]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(0, 1'b0, 8'h12, 8'h34, 1'b0);
    drain(0);

    issue(1, 1'b0, 8'hA5, 8'h5B, 1'b0);
    issue(1, 1'b1, 8'h80, 8'h01, 1'b0);
    issue(1, 1'b0, 8'h7F, 8'h01, 1'b0);
    drain(1);

    fork
      sweep(0, 550);
      sweep(1, 700);
    join

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", pass, total + 1);
    $fatal(1, "watchdog");
  end

endmodule
